// File: rtl/timer_apb_regs.sv
// timer_apb_regs: APB register block for an 8-bit prescaled up/down timer with sticky overflow/underflow flags
module timer_apb_regs #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic       tmr_ovf,
    output logic       tmr_udf
);
    logic [7:0] tdr, tcr, tcnt;
    logic [1:0] tsr, tsr_nxt;
    logic [3:0] psc, wcnt, mask;
    logic       access, bad, wr_ok, load, en, dir, tick, ovf_set, udf_set;
    assign access  = psel & penable;
    assign pready  = access & (wcnt == 4'(WAIT_CYCLES));
    assign bad     = |paddr[7:2];
    assign pslverr = pready & (bad | (pwrite & paddr[1:0] == 2'd3));
    assign wr_ok   = pready & pwrite & !bad;
    assign load    = tcr[7];
    assign dir     = tcr[5];
    assign en      = tcr[4];
    assign mask    = 4'((5'd2 << tcr[1:0]) - 5'd1);
    assign tick    = en & !load & ((psc & mask) == mask);
    assign ovf_set = tick & !dir & (tcnt == 8'hFF);
    assign udf_set = tick & dir & (tcnt == 8'h00);
    // hardware set is OR'ed in after the software clear so it wins a same-cycle collision
    assign tsr_nxt = ((wr_ok & paddr[1:0] == 2'd2) ? tsr & pwdata[1:0] : tsr) | {udf_set, ovf_set};
    always_comb begin
        prdata = (!access | bad)        ? 8'h00 :
                 (paddr[1:0] == 2'd0)   ? tdr :
                 (paddr[1:0] == 2'd1)   ? tcr :
                 (paddr[1:0] == 2'd2)   ? {6'b0, tsr} : tcnt;
    end
    always_ff @(posedge pclk) begin
        if (preset) begin
            tdr     <= '0;
            tcr     <= '0;
            tcnt    <= '0;
            tsr     <= '0;
            psc     <= '0;
            wcnt    <= '0;
            tmr_ovf <= 1'b0;
            tmr_udf <= 1'b0;
        end else begin
            wcnt    <= (access & !pready) ? wcnt + 4'd1 : 4'd0;
            psc     <= (!en | load) ? 4'd0 : psc + 4'd1;
            if (wr_ok & paddr[1:0] == 2'd0) tdr <= pwdata;
            if (wr_ok & paddr[1:0] == 2'd1) tcr <= pwdata & 8'hB3;
            tcnt    <= load ? tdr : tick ? (dir ? tcnt - 8'd1 : tcnt + 8'd1) : tcnt;
            tsr     <= tsr_nxt;
            tmr_ovf <= tsr_nxt[0];
            tmr_udf <= tsr_nxt[1];
        end
    end
endmodule

// File: tb/tb_timer_apb_regs.sv
// tb_timer_apb_regs: directed scoreboard bench for timer_apb_regs with zero and three wait states
module tb_timer_apb_regs;
    logic       pclk = 0, preset = 1, penable = 0, pwrite = 0, psel0 = 0, psel3 = 0;
    logic [7:0] paddr = 0, pwdata = 0;
    logic [7:0] prdata0, prdata3;
    logic       pready0, pready3, pslverr0, pslverr3, ovf0, ovf3, udf0, udf3;
    int         cur = 0, checks = 0, errors = 0;
    typedef struct {logic [7:0] rd; logic err; bit rd_chk; int waits;} exp_t;
    exp_t sb[$];
    wire        rdy = (cur == 3) ? pready3 : pready0;
    wire        err = (cur == 3) ? pslverr3 : pslverr0;
    wire [7:0]  rdata = (cur == 3) ? prdata3 : prdata0;

    timer_apb_regs #(.WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
        .pslverr(pslverr0), .tmr_ovf(ovf0), .tmr_udf(udf0));
    timer_apb_regs #(.WAIT_CYCLES(3)) dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
        .pslverr(pslverr3), .tmr_ovf(ovf3), .tmr_udf(udf3));

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input bit exp_err, input int exp_waits, input string tag);
        exp_t e, g;
        int n;
        e.rd = exp_rd; e.err = exp_err; e.rd_chk = !wr; e.waits = exp_waits;
        sb.push_back(e);
        @(negedge pclk);
        cur = d; psel0 = (d == 0); psel3 = (d == 3); penable = 0;
        pwrite = wr; paddr = a; pwdata = wd;
        #1 chk({tag, "_setup_pready"}, 32'(rdy), 0);
        @(negedge pclk);
        penable = 1;
        #1 n = 0;
        while (!rdy && n < 40) begin
            @(negedge pclk);
            #1 n++;
        end
        g = sb.pop_front();
        if (!rdy) begin
            checks++; errors++;
            $error("FAIL %s_timeout observed=no_pready expected=pready", tag);
        end else begin
            chk({tag, "_pslverr"}, 32'(err), 32'(g.err));
            if (g.rd_chk) chk({tag, "_prdata"}, 32'(rdata), 32'(g.rd));
            if (g.waits >= 0) chk({tag, "_waits"}, n, g.waits);
        end
        @(negedge pclk);
        psel0 = 0; psel3 = 0; penable = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        preset = 0;
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_udf", 32'(udf0), 0);
        chk("rst_prdata", 32'(prdata0), 0);
        xfer(0, 0, 8'h00, 0, 8'h00, 0, 0, "rst_tdr");
        xfer(0, 0, 8'h01, 0, 8'h00, 0, 0, "rst_tcr");
        xfer(0, 0, 8'h03, 0, 8'h00, 0, 0, "rst_tcnt");
        // readback, zero wait states
        xfer(0, 1, 8'h00, 8'hFF, 0, 0, 0, "w_tdr");
        xfer(0, 1, 8'h01, 8'h80, 0, 0, 0, "w_tcr");
        xfer(0, 0, 8'h00, 0, 8'hFF, 0, 0, "r_tdr");
        xfer(0, 0, 8'h01, 0, 8'h80, 0, 0, "r_tcr");
        xfer(0, 0, 8'h02, 0, 8'h00, 0, 0, "r_tsr");
        xfer(0, 1, 8'h01, 8'hCC, 0, 0, 0, "w_tcr_rsvd");
        xfer(0, 0, 8'h01, 0, 8'h80, 0, 0, "r_tcr_rsvd");
        // readback, three wait states
        xfer(3, 1, 8'h00, 8'hFF, 0, 0, 3, "w3_tdr");
        xfer(3, 1, 8'h01, 8'h80, 0, 0, 3, "w3_tcr");
        xfer(3, 0, 8'h00, 0, 8'hFF, 0, 3, "r3_tdr");
        xfer(3, 0, 8'h01, 0, 8'h80, 0, 3, "r3_tcr");
        xfer(3, 0, 8'h02, 0, 8'h00, 0, 3, "r3_tsr");
        // load never flags
        xfer(0, 1, 8'h00, 8'h00, 0, 0, 0, "ld_tdr0");
        xfer(0, 1, 8'h01, 8'h80, 0, 0, 0, "ld_tcr");
        xfer(0, 0, 8'h03, 0, 8'h00, 0, 0, "ld_tcnt");
        xfer(0, 0, 8'h02, 0, 8'h00, 0, 0, "ld_tsr");
        // overflow: FE, up, CKS=0, ticks two and four cycles after the enable write
        xfer(0, 1, 8'h00, 8'hFE, 0, 0, 0, "ov_tdr");
        xfer(0, 1, 8'h01, 8'h80, 0, 0, 0, "ov_load");
        xfer(0, 1, 8'h01, 8'h10, 0, 0, 0, "ov_en");
        repeat (3) @(negedge pclk);
        chk("ov_flag_before", 32'(ovf0), 0);
        xfer(0, 0, 8'h03, 0, 8'h00, 0, 0, "ov_tcnt");
        chk("ov_tmr_ovf", 32'(ovf0), 1);
        xfer(0, 0, 8'h02, 0, 8'h01, 0, 0, "ov_tsr");
        xfer(0, 1, 8'h02, 8'h00, 0, 0, 0, "ov_clr");
        xfer(0, 0, 8'h02, 0, 8'h00, 0, 0, "ov_tsr_clr");
        chk("ov_tmr_ovf_clr", 32'(ovf0), 0);
        xfer(0, 1, 8'h01, 8'h00, 0, 0, 0, "ov_stop");
        // underflow: 01, down, divide by 16
        xfer(0, 1, 8'h00, 8'h01, 0, 0, 0, "ud_tdr");
        xfer(0, 1, 8'h01, 8'h80, 0, 0, 0, "ud_load");
        xfer(0, 1, 8'h01, 8'h33, 0, 0, 0, "ud_en");
        repeat (31) @(negedge pclk);
        chk("ud_flag_before", 32'(udf0), 0);
        xfer(0, 0, 8'h03, 0, 8'hFF, 0, 0, "ud_tcnt");
        chk("ud_tmr_udf", 32'(udf0), 1);
        xfer(0, 0, 8'h02, 0, 8'h02, 0, 0, "ud_tsr");
        xfer(0, 1, 8'h02, 8'h02, 0, 0, 0, "ud_w1");
        xfer(0, 0, 8'h02, 0, 8'h02, 0, 0, "ud_tsr_kept");
        xfer(0, 1, 8'h01, 8'h00, 0, 0, 0, "ud_stop");
        // access errors
        xfer(0, 0, 8'h03, 0, 8'hFF, 0, 0, "er_tcnt_pre");
        xfer(0, 1, 8'h03, 8'h55, 0, 1, 0, "er_w_tcnt");
        xfer(0, 0, 8'h03, 0, 8'hFF, 0, 0, "er_tcnt_post");
        xfer(0, 0, 8'h10, 0, 8'h00, 1, 0, "er_r_oob");
        xfer(0, 1, 8'h10, 8'h77, 0, 1, 0, "er_w_oob");
        xfer(0, 0, 8'h00, 0, 8'h01, 0, 0, "er_tdr_same");
        // reset in the access phase of a three-wait TDR write
        @(negedge pclk);
        cur = 3; psel3 = 1; penable = 0; pwrite = 1; paddr = 8'h00; pwdata = 8'hAA;
        @(negedge pclk);
        penable = 1;
        @(negedge pclk);
        preset = 1;
        @(negedge pclk);
        preset = 0; psel3 = 0; penable = 0;
        #1 chk("mr_pready", 32'(pready3), 0);
        chk("mr_pslverr", 32'(pslverr3), 0);
        chk("mr_ovf", 32'(ovf3), 0);
        chk("mr_udf", 32'(udf0), 0);
        xfer(3, 0, 8'h00, 0, 8'h00, 0, 3, "mr_tdr");
        xfer(3, 0, 8'h01, 0, 8'h00, 0, 3, "mr_tcr");
        xfer(0, 0, 8'h02, 0, 8'h00, 0, 0, "mr_tsr0");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_apb_regs.md
# timer_apb_regs

APB responder for the 8-bit timer: it decodes APB accesses from the CPU bus functional model (BFM) into the timer registers TDR, TCR, TSR and TCNT. It also contains the prescaler and the 8-bit up/down counter, and flags overflow and underflow. It is the slave end of the access sequence driven by the CPU BFM. Wait-state insertion is parameterised so the same benches run with zero or more wait states.

## Interface
- WAIT_CYCLES, 0, number of wait states per access phase (0..15); pready rises after this many access cycles.
- pclk  in  1  APB clock; all logic on rising edge.
- preset  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  8  register address.
- pwdata  in  8  write data.
- prdata  out  8  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error response, valid with pready.
- tmr_ovf  out  1  mirror of TSR[0].
- tmr_udf  out  1  mirror of TSR[1].

## Operation
- **Register map**
  - 0x00 TDR: RW, reset 0x00.
  - 0x01 TCR: RW, reset 0x00.
    - [7] LOAD. While 1, TCNT <= TDR every cycle.
    - [5] DIR: 0 = up, 1 = down.
    - [4] EN.
    - [1:0] CKS: tick every 2, 4, 8 or 16 pclk for CKS = 0, 1, 2, 3.
    - [6], [3:2]: read 0, writes ignored.
  - 0x02 TSR: reset 0x00.
    - [0] OVF and [1] UDF are sticky.
    - Writing 0 to a bit clears it; writing 1 has no effect.
    - [7:2] read 0.
  - 0x03 TCNT: RO, reset 0x00.
- **Address and access errors**
  - A write to 0x03 is ignored and returns pslverr = 1.
  - Any address above 0x03 returns pslverr = 1, prdata = 0x00, no state change.
- **Transfer completion**
  - A transfer completes on the edge where psel & penable & pready = 1.
  - Write side effects take place on that edge.
- **Prescaler**
  - 4-bit counter, cleared while EN = 0, LOAD = 1 or reset.
  - Otherwise increments every cycle.
  - Tick when prescaler[CKS:0] is all ones (i.e. every 2^(CKS+1) cycles).
- **Counter on tick (EN = 1, LOAD = 0)**
  - DIR = 0: TCNT <= TCNT + 1 (mod 256). FF→00 sets OVF.
  - DIR = 1: TCNT <= TCNT − 1. 00→FF sets UDF.
- **LOAD behaviour**
  - LOAD never sets OVF or UDF, even when the loaded value differs from the old one.
  - LOAD has priority over a tick in the same cycle.
- **Simultaneous events**
  - A hardware set of a TSR flag and a software clear of the same bit in the same cycle: the set wins (flag = 1).
  - A TCR write and a tick in the same cycle: the tick uses the old TCR.
- **Reset**
  - Reset at any time, including mid-transfer, returns all registers, the prescaler and the wait counter to 0.
  - Any in-flight transfer is abandoned. The master must restart it from the setup phase.

## Timing
- **Wait counter**
  - Increments each cycle with psel & penable & !pready.
  - Cleared otherwise.
  - pready = psel & penable & (wait counter == WAIT_CYCLES), combinational.
  - WAIT_CYCLES = 0 gives pready in the first access cycle.
- **Idle and setup outputs**
  - pready = 0 and pslverr = 0 outside the access phase.
- **Read data**
  - prdata is combinational from the current register value during the access phase; 0x00 otherwise.
  - A read in the cycle after a write to the same register returns the new value.
- **Write visibility**
  - A TCR or TDR write becomes visible to the counter logic on the cycle after the completing edge.
  - The first tick after enabling comes 2^(CKS+1) cycles after the EN write completes.
- **Outputs**
  - tmr_ovf and tmr_udf are registered: they rise on the same edge as the TSR bit.
  - Reset values of all outputs: 0.

## Test plan
- **Register readback:** write TDR = 0xFF, TCR = 0x80, then read back → 0xFF and 0x80. TSR reads 0x00 with pslverr = 0. Repeat with WAIT_CYCLES = 3 → pready is high only in the 4th access cycle.
- **Load does not flag:** write TDR = 0xFF, TCR = 0x80, then TDR = 0x00, TCR = 0x80. TCNT reads 0x00 and TSR reads 0x00.
- **Overflow:** load TDR = 0xFE, then write TCR = 0x10 (up, CKS = 0). After 4 pclk, TCNT = 0x00, TSR = 0x01 and tmr_ovf = 1. Write TSR = 0x00 → TSR reads 0x00.
- **Underflow:** load 0x01, then write TCR = 0x33 (down, div 16). After 32 cycles, TCNT = 0xFF and TSR = 0x02. Writing TSR = 0x02 leaves UDF set.
- **Errors:** write 0x55 to 0x03 → pslverr = 1 and TCNT unchanged. Read 0x10 → pslverr = 1, prdata = 0x00.
- **Reset mid-transfer:** assert preset during the access phase of a TDR write of 0xAA. TDR = 0x00, pready = 0, outputs 0 on the next cycle.
